// File: rtl/pitch_classifier.sv
// Pitch classifier: hysteresis zero-crossing period measurement, sequential
// semitone/octave scan against an elaboration-time bound table, debounced output.
module pitch_classifier #(
  parameter int clk_mhz   = 50,
  parameter int w_mic     = 24,
  parameter int w_period  = 20,
  parameter int n_octaves = 3,
  parameter int tol_pct   = 3,
  parameter int hyst      = 0,
  parameter int stable_n  = 4,
  localparam int w_oct    = (n_octaves > 1) ? $clog2(n_octaves) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [w_mic-1:0] mic,
  output logic [3:0]              note,
  output logic [w_oct-1:0]        octave,
  output logic                    note_valid,
  output logic                    note_strobe,
  output logic [w_period-1:0]     period
);

  localparam int NC    = 12 * n_octaves;
  localparam int W_IDX = $clog2(NC);
  localparam logic [W_IDX-1:0]           IDX_LAST = W_IDX'(NC - 1);
  localparam logic [w_period-1:0]        PMAX     = '1;
  localparam logic signed [w_mic-1:0]    HYS_P    = w_mic'(hyst);
  localparam logic signed [w_mic-1:0]    HYS_N    = -HYS_P;
  localparam logic [7:0]                 RUN_N    = 8'(stable_n);

  typedef struct packed {
    logic [3:0]       note;
    logic [w_oct-1:0] oct;
  } res_t;

  localparam res_t NONE = '{note: 4'hF, oct: '0};

  typedef logic [NC-1:0][w_period-1:0] tbl_t;

  function automatic logic [63:0] freq100(input int n);
    case (n)
      0:       return 64'd26163;
      1:       return 64'd27718;
      2:       return 64'd29366;
      3:       return 64'd31113;
      4:       return 64'd32963;
      5:       return 64'd34923;
      6:       return 64'd36999;
      7:       return 64'd39200;
      8:       return 64'd41530;
      9:       return 64'd44000;
      10:      return 64'd46616;
      default: return 64'd49388;
    endcase
  endfunction

  // Entry 12*k+n is the nominal period of semitone n in octave k, scaled by pct/100.
  function automatic tbl_t mk_tbl(input int pct);
    tbl_t        t;
    logic [63:0] c;
    t = '0;
    for (int k = 0; k < n_octaves; k++) begin
      for (int n = 0; n < 12; n++) begin
        c = (64'(clk_mhz) * 64'd100000000) / (freq100(n) << k);
        c = (c * 64'(pct)) / 64'd100;
        t[12*k+n] = c[w_period-1:0];
      end
    end
    return t;
  endfunction

  localparam tbl_t LO = mk_tbl(100 - tol_pct);
  localparam tbl_t HI = mk_tbl(100 + tol_pct);

  // ---------------- crossing detector ----------------
  logic signed [w_mic-1:0] prev;
  logic armed, armed_eff, crossing;

  // Arming looks at prev directly so a single-cycle sign flip still counts.
  assign armed_eff = armed | (prev < HYS_N);
  assign crossing  = armed_eff & (mic >= HYS_P);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= mic;
      armed <= armed_eff & ~crossing;
    end
  end

  // ---------------- period counter ----------------
  logic [w_period-1:0] cnt, meas_val;
  logic tmo, meas_vld;

  assign tmo      = ~crossing & (cnt == PMAX - w_period'(1));
  assign meas_vld = crossing | tmo;
  assign meas_val = crossing ? cnt : PMAX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      period <= '0;
    end else begin
      if (crossing)          cnt <= w_period'(1);
      else if (cnt != PMAX)  cnt <= cnt + w_period'(1);
      if (meas_vld) period <= meas_val;
    end
  end

  // ---------------- scanner FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RES} state_t;

  state_t              state, state_n;
  logic [w_period-1:0] p, p_n, pend_p, pp_n, ev_p;
  logic [W_IDX-1:0]    idx, idx_n;
  logic [3:0]          n_idx, n_n;
  logic [w_oct-1:0]    k_idx, k_n;
  res_t                res, res_n;
  logic                pend_vld, pv_n, pend_tmo, pt_n;
  logic                ev_vld, ev_tmo, hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      p        <= '0;
      idx      <= '0;
      n_idx    <= '0;
      k_idx    <= '0;
      res      <= NONE;
      pend_vld <= 1'b0;
      pend_tmo <= 1'b0;
      pend_p   <= '0;
    end else begin
      state    <= state_n;
      p        <= p_n;
      idx      <= idx_n;
      n_idx    <= n_n;
      k_idx    <= k_n;
      res      <= res_n;
      pend_vld <= pv_n;
      pend_tmo <= pt_n;
      pend_p   <= pp_n;
    end
  end

  always_comb begin
    state_n = state;
    p_n     = p;
    idx_n   = idx;
    n_n     = n_idx;
    k_n     = k_idx;
    res_n   = res;
    pv_n    = pend_vld;
    pt_n    = pend_tmo;
    pp_n    = pend_p;
    ev_vld  = 1'b0;
    ev_tmo  = 1'b0;
    ev_p    = p;
    hit     = 1'b0;
    case (state)
      S_IDLE: begin
        pv_n = 1'b0;
        if (meas_vld) begin
          ev_vld = 1'b1;
          ev_tmo = tmo;
          ev_p   = meas_val;
        end else if (pend_vld) begin
          ev_vld = 1'b1;
          ev_tmo = pend_tmo;
          ev_p   = pend_p;
        end
      end
      S_SCAN: begin
        hit = (LO[idx] < p) && (p < HI[idx]);
        if (meas_vld) begin
          ev_vld = 1'b1;
          ev_tmo = tmo;
          ev_p   = meas_val;
        end else if (p == PMAX) begin
          state_n = S_RES;
          res_n   = NONE;
        end else if (hit) begin
          state_n = S_RES;
          res_n   = '{note: n_idx, oct: k_idx};
        end else if (idx == IDX_LAST) begin
          state_n = S_RES;
          res_n   = NONE;
        end else begin
          idx_n = idx + W_IDX'(1);
          if (n_idx == 4'd11) begin
            n_n = 4'd0;
            k_n = k_idx + w_oct'(1);
          end else begin
            n_n = n_idx + 4'd1;
          end
        end
      end
      S_RES: begin
        state_n = S_IDLE;
        // Held for exactly one cycle; IDLE picks it up next.
        if (meas_vld) begin
          pv_n = 1'b1;
          pt_n = tmo;
          pp_n = meas_val;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (ev_vld) begin
      if (ev_tmo) begin
        state_n = S_RES;
        res_n   = NONE;
      end else begin
        state_n = S_SCAN;
        p_n     = ev_p;
        idx_n   = '0;
        n_n     = '0;
        k_n     = '0;
      end
    end
  end

  // ---------------- debouncer ----------------
  res_t       r, r_n, out_q, out_n;
  logic [7:0] run, run_n;
  logic       strobe_n;

  always_comb begin
    r_n      = r;
    run_n    = run;
    out_n    = out_q;
    strobe_n = 1'b0;
    if (state == S_RES) begin
      if (res == r) begin
        run_n = (run == 8'hFF) ? run : run + 8'd1;
      end else begin
        r_n   = res;
        run_n = 8'd1;
      end
      if (run_n >= RUN_N) begin
        out_n    = r_n;
        strobe_n = (r_n != out_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= NONE;
      run         <= '0;
      out_q       <= NONE;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      r           <= r_n;
      run         <= run_n;
      out_q       <= out_n;
      note_valid  <= (out_n.note != 4'hF);
      note_strobe <= strobe_n;
    end
  end

  assign note   = out_q.note;
  assign octave = out_q.oct;

endmodule

// File: tb/tb_pitch_classifier.sv
// Directed bench for pitch_classifier: two scaled instances (1 MHz clock, 12-bit period)
// cover lock/latency/octave/reset on one and tolerance/hysteresis/timeout on the other.
module tb_pitch_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_a, rst_b;
  logic signed [23:0]  mic_a, mic_b;
  logic [3:0]          note_a, note_b;
  logic [1:0]          oct_a, oct_b;
  logic                nv_a, nv_b, ns_a, ns_b;
  logic [11:0]         per_a, per_b;

  int cyc = 0, n_chk = 0, n_err = 0;
  int st_a = 0, st_b = 0, last_a = 0, last_b = 0, t_a = 0, t_b = 0, snap = 0;

  // A: tol 3 %, no hysteresis, 4-deep debounce.
  pitch_classifier #(.clk_mhz(1), .w_mic(24), .w_period(12), .n_octaves(3),
                     .tol_pct(3), .hyst(0), .stable_n(4)) dut_a (
    .clk(clk), .rst(rst_a), .mic(mic_a), .note(note_a), .octave(oct_a),
    .note_valid(nv_a), .note_strobe(ns_a), .period(per_a));

  // B: tol 2 % so the A upper bound does not overlap G#, hysteresis 50, no debounce.
  pitch_classifier #(.clk_mhz(1), .w_mic(24), .w_period(12), .n_octaves(3),
                     .tol_pct(2), .hyst(50), .stable_n(1)) dut_b (
    .clk(clk), .rst(rst_b), .mic(mic_b), .note(note_b), .octave(oct_b),
    .note_valid(nv_b), .note_strobe(ns_b), .period(per_b));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ns_a) begin st_a <= st_a + 1; last_a <= cyc; end
    if (ns_b) begin st_b <= st_b + 1; last_b <= cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_a(input int v, input int n);
    mic_a = 24'(v);
    t_a   = cyc;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_b(input int v, input int n);
    mic_b = 24'(v);
    t_b   = cyc;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    mic_a = -24'sd1000;
    mic_b = 24'sd0;
    repeat (3) @(negedge clk);
    chk("rst_note_a",   note_a, 4'hF);
    chk("rst_oct_a",    oct_a,  0);
    chk("rst_valid_a",  nv_a,   0);
    chk("rst_strobe_a", ns_a,   0);
    chk("rst_period_a", per_a,  0);
    chk("rst_note_b",   note_b, 4'hF);
    chk("rst_period_b", per_b,  0);

    // A4: period 2272 at 1 MHz, first crossing is a short (none) measurement.
    rst_a = 1'b0;
    drive_a(-1000, 100);
    for (int j = 1; j <= 5; j++) begin
      drive_a(1000, 1136);
      if (j == 4) chk("a4_no_early_strobe", st_a, 0);
      if (j == 5) begin
        chk("a4_period",  per_a, 2272);
        chk("a4_note",    note_a, 9);
        chk("a4_oct",     oct_a, 0);
        chk("a4_valid",   nv_a, 1);
        chk("a4_strobes", st_a, 1);
        chk("a4_latency", last_a - t_a, 12);
      end
      drive_a(-1000, 1136);
    end

    // C6: period 955, candidate 24.
    for (int j = 1; j <= 5; j++) begin
      drive_a(1000, 478);
      if (j == 5) begin
        chk("c6_period",  per_a, 955);
        chk("c6_note",    note_a, 0);
        chk("c6_oct",     oct_a, 2);
        chk("c6_strobes", st_a, 2);
        chk("c6_latency", last_a - t_a, 27);
      end
      drive_a(-1000, 477);
    end

    // Reset while scanning.
    drive_a(1000, 5);
    #3 rst_a = 1'b1;
    #1;
    chk("mid_rst_note",   note_a, 4'hF);
    chk("mid_rst_oct",    oct_a,  0);
    chk("mid_rst_valid",  nv_a,   0);
    chk("mid_rst_strobe", ns_a,   0);
    chk("mid_rst_period", per_a,  0);
    snap = st_a;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_no_strobe", st_a, snap);
    chk("post_rst_note",      note_a, 4'hF);

    // B: hysteresis ripple must not cross.
    rst_b = 1'b0;
    for (int j = 0; j < 10; j++) begin
      drive_b(30, 10);
      drive_b(-30, 10);
    end
    chk("hyst_period",  per_b, 0);
    chk("hyst_note",    note_b, 4'hF);
    chk("hyst_strobes", st_b, 0);

    // Tolerance: 2317 == hi[A] -> none, 2316 -> A.
    drive_b(-200, 100);
    drive_b(200, 1159);
    drive_b(-200, 1158);
    drive_b(200, 1159);
    chk("hi_period",  per_b, 2317);
    chk("hi_note",    note_b, 4'hF);
    chk("hi_strobes", st_b, 0);
    drive_b(-200, 1157);
    drive_b(200, 1159);
    chk("hi1_period",  per_b, 2316);
    chk("hi1_note",    note_b, 9);
    chk("hi1_oct",     oct_b, 0);
    chk("hi1_valid",   nv_b, 1);
    chk("hi1_strobes", st_b, 1);
    chk("hi1_latency", last_b - t_b, 12);

    // Silence: counter saturates once, forcing none.
    drive_b(0, 4200);
    chk("tmo_period",  per_b, 12'hFFF);
    chk("tmo_note",    note_b, 4'hF);
    chk("tmo_oct",     oct_b, 0);
    chk("tmo_valid",   nv_b, 0);
    chk("tmo_strobes", st_b, 2);
    drive_b(0, 4200);
    chk("tmo_once_strobes", st_b, 2);
    chk("tmo_once_period",  per_b, 12'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
